dpram_port_responder: RTL and testbench
=======================================

# dpram_port_responder

Single-clock memory responder that services the two `ram_if`-style port initiators (A and B) used across the dual-port RAM environment. Both ports share one single-port storage array: at most one access per cycle, with round-robin arbitration between the ports. The responder clears the array after reset through an init sweep. It is the memory-side counterpart of the port agents, and serves as the golden responder and the emulation target for dual-port behaviour.

## Interface
Parameters:
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.
- `DEPTH`, `2**ADDR_W`: number of words.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_a` / `req_b`  in  1  access request from port A / B.
- `we_a` / `we_b`  in  1  1 = write, 0 = read.
- `addr_a` / `addr_b`  in  ADDR_W  word address.
- `wdata_a` / `wdata_b`  in  DATA_W  write data.
- `gnt_a` / `gnt_b`  out  1  access performed at this edge (combinational).
- `rvalid_a` / `rvalid_b`  out  1  read data valid, one-cycle pulse.
- `rdata_a` / `rdata_b`  out  DATA_W  read data; holds its last value when rvalid is low.
- `init_done`  out  1  high once the clear sweep is complete.

## Operation
- FSM states are INIT and RUN.
- `rst` high: state goes to INIT and `init_cnt` goes to 0.
- INIT: each cycle writes 0 to `mem[init_cnt]` and increments `init_cnt`. At `init_cnt == DEPTH-1` the next state is RUN.
- `gnt_a` and `gnt_b` are forced to 0 in INIT. Requests are ignored, not queued.
- RUN: the arbiter grants at most one port per cycle.
  - Only one port requests: that port is granted.
  - Both ports request: the port named by `prio` is granted.
- `prio` resets to A. After any grant, `prio` points to the non-granted port. With no grant, `prio` is unchanged.
- Initiator rule: `req`, `we`, `addr` and `wdata` stay stable until the cycle in which `gnt` is high. The request may drop after that cycle.
- Granted write: `mem[addr] <= wdata` at that edge.
- Granted read: `mem[addr]` is registered into `rdata_x`, and `rvalid_x` = 1 in the next cycle.
- Collisions are serialized; there is never an undefined result. Same address, simultaneous write and read: the port granted first wins.
  - Write first: the read (granted the next cycle) returns the new data.
  - Read first: the read returns the old data.
- Back-to-back grants to the same port are legal when the other port is idle, giving 1 access per cycle.

## Timing
- Reset values:
  - `gnt_a`, `gnt_b` = 0.
  - `rvalid_a`, `rvalid_b` = 0.
  - `rdata_a`, `rdata_b` = 0.
  - `init_done` = 0.
  - `prio` = A.
  - `init_cnt` = 0.
- `init_done` is registered. Counting the first edge with `rst` low as INIT cycle 0, `init_done` is 1 from cycle DEPTH onward (256 for the default). Grants are possible from that same cycle.
- Grant latency is 0 cycles: `gnt` is combinational from `req`, state and `prio`.
- Read latency is 1 cycle from the grant edge to `rvalid`/`rdata`.
- Worst-case wait under continuous contention is 1 cycle.
- Reset mid-operation:
  - Any pending `rvalid` is dropped; `rvalid` is 0 in the cycle after `rst` is sampled high.
  - The INIT sweep restarts from 0, so all words read 0 afterwards.
- `rst` held for several cycles: the design stays in INIT with `init_cnt` = 0.

## Structure
- Package `dpram_resp_pkg`:
  - `port_e` enum (PORT_A, PORT_B).
  - `state_e` enum (INIT, RUN).
  - Default width constants.
- Sub-module `rr_arb2`: a two-requester round-robin arbiter. It holds the `prio` register and has inputs `req[1:0]`, `en` and outputs `gnt[1:0]`.
- The top level contains the FSM, the init counter, the memory array, the address/data mux and the per-port read registers.

## Test plan
- Release `rst` → `init_done` = 0 for 256 cycles, then 1. Requests during INIT get `gnt` = 0. A read of 0x7F after INIT returns 0x00.
- A writes 0xA5 to 0x10; B later reads 0x10 → `gnt_b` in the same cycle, `rvalid_b` the next cycle with `rdata_b` = 0xA5, `rvalid_a` stays 0.
- Both ports hold `req` for 4 cycles with `prio` = A → grant order A, B, A, B. Exactly one `gnt` per cycle; `prio` ends at A.
- Same address 0x3C, old value 0x11. A writes 0x5A while B reads, `prio` = A → `rdata_b` = 0x5A. Repeat with `prio` = B → `rdata_b` = 0x11.
- A reads 0x20; assert `rst` in the `rvalid_a` cycle's predecessor → `rvalid_a` never pulses. After the new INIT, a read of 0x20 returns 0x00.
- A issues reads to 0x00..0x03 back-to-back while B is idle → 4 consecutive grants and `rvalid_a` high for 4 consecutive cycles with the correct data.

Source files
------------

// File: rtl/dpram_port_responder_pkg.sv
// Shared types and default widths for the dual-port responder slice.
package dpram_resp_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/dpram_port_responder_if.sv
// Two ram-style initiator ports (A and B) as seen by the memory responder.
interface dpram_port_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_a,    req_b;
    logic              we_a,     we_b;
    logic [ADDR_W-1:0] addr_a,   addr_b;
    logic [DATA_W-1:0] wdata_a,  wdata_b;
    logic              gnt_a,    gnt_b;
    logic              rvalid_a, rvalid_b;
    logic [DATA_W-1:0] rdata_a,  rdata_b;

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b
    );

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b
    );
endinterface

// File: rtl/dpram_port_responder_rr_arb2.sv
// Two-requester round-robin arbiter; grant is combinational, prio moves to the loser after each grant.
// Backpressure: a requester that loses simply keeps req high and wins the next cycle.
module rr_arb2
    import dpram_resp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    port_e prio;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (prio == PORT_A) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= PORT_A;
        end else if (gnt[0]) begin
            prio <= other_port(PORT_A);
        end else if (gnt[1]) begin
            prio <= other_port(PORT_B);
        end
    end

endmodule

// File: rtl/dpram_port_responder.sv
// Shared single-port array serving ports A/B: clears itself after reset, then one access per cycle.
// Grant is 0-cycle, read data 1 cycle after grant; an ungranted port holds its request until gnt.
module dpram_port_responder
    import dpram_resp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    dpram_port_if.slave  port,
    output logic         init_done
);

    state_e            state, next_state;
    logic [ADDR_W-1:0] init_cnt;
    logic [1:0]        gnt;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] rd_word;
    logic              rvalid_a, rvalid_b;
    logic [DATA_W-1:0] rdata_a,  rdata_b;
    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        next_state = state;
        if (state == INIT && init_cnt == ADDR_W'(DEPTH - 1)) begin
            next_state = RUN;
        end
    end

    // init_done tracks the next state so it rises together with the first grantable cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= next_state;
            init_done <= (next_state == RUN);
            if (state == INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({port.req_b, port.req_a}),
        .en  (state == RUN),
        .gnt (gnt)
    );

    assign acc_we    = gnt[1] ? port.we_b    : port.we_a;
    assign acc_addr  = gnt[1] ? port.addr_b  : port.addr_a;
    assign acc_wdata = gnt[1] ? port.wdata_b : port.wdata_a;
    assign rd_word   = mem[acc_addr];

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[init_cnt] <= '0;
        end else if ((|gnt) && acc_we) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
        end else begin
            rvalid_a <= gnt[0] & ~port.we_a;
            rvalid_b <= gnt[1] & ~port.we_b;
            if (gnt[0] && !port.we_a) rdata_a <= rd_word;
            if (gnt[1] && !port.we_b) rdata_b <= rd_word;
        end
    end

    assign port.gnt_a    = gnt[0];
    assign port.gnt_b    = gnt[1];
    assign port.rvalid_a = rvalid_a;
    assign port.rvalid_b = rvalid_b;
    assign port.rdata_a  = rdata_a;
    assign port.rdata_b  = rdata_b;

endmodule

// File: tb/tb_dpram_port_responder.sv
// Directed bench: stimulus pushes expected read data, a negedge monitor pops and compares on rvalid.
module tb_dpram_port_responder;

    logic clk = 1'b0;
    logic rst;
    logic init_done;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    dpram_port_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    dpram_port_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .port      (bus),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.rvalid_a === 1'b1) begin
                if (exp_a.size() == 0) check("unexpected_rvalid_a", 1, 0);
                else check("rdata_a", bus.rdata_a, exp_a.pop_front());
            end
            if (bus.rvalid_b === 1'b1) begin
                if (exp_b.size() == 0) check("unexpected_rvalid_b", 1, 0);
                else check("rdata_b", bus.rdata_b, exp_b.pop_front());
            end
        end
    end

    // One cycle: drive both ports at the negedge, check grants, queue expected read data, advance.
    task automatic cyc(input string nm,
                       input logic ra, input logic wa, input logic [7:0] aa, input logic [7:0] da,
                       input logic rb, input logic wb, input logic [7:0] ab, input logic [7:0] db,
                       input logic ega, input logic egb,
                       input logic [7:0] rda, input logic [7:0] rdb);
        bus.req_a = ra; bus.we_a = wa; bus.addr_a = aa; bus.wdata_a = da;
        bus.req_b = rb; bus.we_b = wb; bus.addr_b = ab; bus.wdata_b = db;
        #1;
        check({nm, "_gnt_a"}, bus.gnt_a, ega);
        check({nm, "_gnt_b"}, bus.gnt_b, egb);
        if (ega && !wa) exp_a.push_back(rda);
        if (egb && !wb) exp_b.push_back(rdb);
        @(posedge clk);
        @(negedge clk);
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
    endtask

    // Called at a negedge right after rst drops; holds a read request on A through the whole sweep.
    task automatic init_phase(input logic [7:0] a);
        bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = a;
        #1;
        check("init_done_pre", init_done, 0);
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check("init_done_sweep", init_done, (i == 255));
            check("init_gnt_a", bus.gnt_a, (i == 255));
        end
        exp_a.push_back(8'h00);
        @(posedge clk);
        @(negedge clk);
        bus.req_a = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_a = 0; bus.we_a = 0; bus.addr_a = 0; bus.wdata_a = 0;
        bus.req_b = 0; bus.we_b = 0; bus.addr_b = 0; bus.wdata_b = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt_a", bus.gnt_a, 0);
        check("rst_gnt_b", bus.gnt_b, 0);
        check("rst_rvalid_a", bus.rvalid_a, 0);
        check("rst_rvalid_b", bus.rvalid_b, 0);
        check("rst_rdata_a", bus.rdata_a, 0);
        check("rst_rdata_b", bus.rdata_b, 0);
        check("rst_init_done", init_done, 0);
        mon_en = 1'b1;
        rst = 1'b0;
        init_phase(8'h7F);

        // Write on A, later read on B
        cyc("wrA",  1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 1,0, 8'h00,8'h00);
        cyc("idle", 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0, 8'h00,8'h00);
        cyc("rdB",  0,0,8'h00,8'h00, 1,0,8'h10,8'h00, 0,1, 8'h00,8'hA5);
        check("rdB_rvalid_b", bus.rvalid_b, 1);
        check("rdB_rvalid_a", bus.rvalid_a, 0);

        // Continuous contention starting with prio on A
        cyc("rr0", 1,0,8'h10,8'h00, 1,0,8'h7F,8'h00, 1,0, 8'hA5,8'h00);
        cyc("rr1", 1,0,8'h10,8'h00, 1,0,8'h7F,8'h00, 0,1, 8'h00,8'h00);
        cyc("rr2", 1,0,8'h10,8'h00, 1,0,8'h7F,8'h00, 1,0, 8'hA5,8'h00);
        cyc("rr3", 1,0,8'h10,8'h00, 1,0,8'h7F,8'h00, 0,1, 8'h00,8'h00);
        cyc("rr_end", 1,0,8'h10,8'h00, 1,0,8'h7F,8'h00, 1,0, 8'hA5,8'h00);

        // Same-address collision, write granted first (prio currently B -> flip to A first)
        cyc("seed3C", 0,0,8'h00,8'h00, 1,0,8'h10,8'h00, 0,1, 8'h00,8'hA5);
        cyc("old3C",  1,1,8'h3C,8'h11, 0,0,8'h00,8'h00, 1,0, 8'h00,8'h00);
        cyc("flipA",  0,0,8'h00,8'h00, 1,0,8'h10,8'h00, 0,1, 8'h00,8'hA5);
        cyc("colW1",  1,1,8'h3C,8'h5A, 1,0,8'h3C,8'h00, 1,0, 8'h00,8'h00);
        cyc("colW2",  0,0,8'h00,8'h00, 1,0,8'h3C,8'h00, 0,1, 8'h00,8'h5A);

        // Same collision with prio on B: read wins and sees the old value
        cyc("old3Cb", 1,1,8'h3C,8'h11, 0,0,8'h00,8'h00, 1,0, 8'h00,8'h00);
        cyc("colR1",  1,1,8'h3C,8'h5A, 1,0,8'h3C,8'h00, 0,1, 8'h00,8'h11);
        cyc("colR2",  1,1,8'h3C,8'h5A, 0,0,8'h00,8'h00, 1,0, 8'h00,8'h00);
        cyc("post3C", 0,0,8'h00,8'h00, 1,0,8'h3C,8'h00, 0,1, 8'h00,8'h5A);

        // Reset at the grant edge of a read: rvalid must never appear, memory is cleared
        cyc("wr20", 1,1,8'h20,8'h77, 0,0,8'h00,8'h00, 1,0, 8'h00,8'h00);
        bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 8'h20;
        rst = 1'b1;
        #1;
        check("rst_mid_gnt_a", bus.gnt_a, 1);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_rvalid_a", bus.rvalid_a, 0);
        check("rst_mid_init_done", init_done, 0);
        rst = 1'b0;
        init_phase(8'h20);

        // Back-to-back writes then reads on A with B idle
        for (int i = 0; i < 4; i++) begin
            cyc("b2b_wr", 1,1,8'(i),8'(8'hC0 + i), 0,0,8'h00,8'h00, 1,0, 8'h00,8'h00);
        end
        for (int i = 0; i < 4; i++) begin
            bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 8'(i);
            #1;
            check("b2b_gnt_a", bus.gnt_a, 1);
            exp_a.push_back(8'(8'hC0 + i));
            @(posedge clk);
            @(negedge clk);
            check("b2b_rvalid_a", bus.rvalid_a, 1);
        end
        bus.req_a = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pending_a", exp_a.size(), 0);
        check("pending_b", exp_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
